cdc_fifo_wr_arbiter: RTL and testbench
======================================

// Module: cdc_fifo_wr_arbiter
// PURPOSE
//  Shares the write port of one cdc_async_fifo_w_ocup instance among NUM_REQ requesters in the write domain.
//  Round-robin, burst-locked arbitration: a winner keeps the port until its last beat or MAX_BURST beats.
//  A burst starts only when fifo occupancy shows room for a full MAX_BURST.
//  Sits between producer agents and the FIFO wr side: fifo_wr_* drive wr_en_i/wr_data_i; wr_full_o/ocup_o feed back.
// PARAMETERS
//  NUM_REQ    4   number of requesters, >=2
//  WIDTH      8   data width, equals FIFO WIDTH
//  SLOTS      8   FIFO depth, power of 2, equals FIFO SLOTS
//  MAX_BURST  4   max beats per grant, 1..SLOTS
//  IDLE_TMO   16  consecutive stall cycles (granted valid low) before forced release, >=1
// PORTS
//  clk_wr          in   1                   write-domain clock
//  arst_wr_n       in   1                   asynchronous active-low reset
//  req_valid_i     in   NUM_REQ             per-requester beat valid
//  req_data_i      in   NUM_REQ x WIDTH     per-requester beat data
//  req_last_i      in   NUM_REQ             beat is last of requester packet
//  req_ready_o     out  NUM_REQ             beat accepted this cycle (one-hot or zero)
//  fifo_wr_en_o    out  1                   to FIFO wr_en_i
//  fifo_wr_data_o  out  WIDTH               to FIFO wr_data_i
//  fifo_wr_full_i  in   1                   from FIFO wr_full_o
//  fifo_ocup_i     in   $clog2(SLOTS)+1     from FIFO ocup_o
//  grant_id_o      out  $clog2(NUM_REQ)     registered current/last grant index
//  busy_o          out  1                   1 while in BURST
// BEHAVIOUR
//  Reset (arst_wr_n=0, async): state=IDLE, rr_ptr=0, grant_id_o=0, beat_cnt=0, tmo_cnt=0;
//   busy_o=0, fifo_wr_en_o=0, req_ready_o=0, fifo_wr_data_o=0 (mux defaults to 0 outside BURST).
//  free = SLOTS - fifo_ocup_i, width $clog2(SLOTS)+1; admission when free >= MAX_BURST.
//  IDLE: if |req_valid_i and admission, pick first valid at or after rr_ptr (wrap mod NUM_REQ);
//   register grant_id_o, beat_cnt=0, tmo_cnt=0, go BURST next edge. 1-cycle arbitration latency.
//   No admission -> stay IDLE, nothing accepted.
//  BURST: beat = req_valid_i[g] & ~fifo_wr_full_i (combinational, g=grant_id_o).
//   fifo_wr_en_o=beat; req_ready_o[g]=beat, others 0; fifo_wr_data_o=req_data_i[g].
//   On beat: beat_cnt++, tmo_cnt=0. Burst ends on beat with req_last_i[g] or beat_cnt==MAX_BURST-1.
//   Valid low: tmo_cnt++; tmo_cnt==IDLE_TMO-1 with valid still low -> release.
//   Full with valid high: stall, tmo_cnt held (not a timeout).
//   End/release: state=IDLE, rr_ptr=g+1 mod NUM_REQ, beat_cnt=0. Next grant earliest 1 cycle later.
//  Never drives fifo_wr_en_o while fifo_wr_full_i=1; never more than one req_ready_o bit set.
//  Packets longer than MAX_BURST are split; requester re-arbitrates for the remainder.
//  Reset mid-burst: immediate return to reset values; partial packet already in FIFO is not retracted.
//  Free space from the FIFO is conservative (rd ptr sync lag), so over-admission cannot occur.
// STRUCTURE
//  cdc_pkg: arb_state_t enum {IDLE, BURST}; function rr_pick(valid, ptr) returning index + found flag.
//  Sub-module cdc_rr_arbiter (combinational, NUM_REQ param): valid+rr_ptr -> one-hot/index winner.
//  Top: FSM, beat/tmo counters, grant register, data mux. Assertions: onehot0(req_ready_o),
//   !(fifo_wr_en_o && fifo_wr_full_i), MAX_BURST<=SLOTS, SLOTS power of 2.
// TESTING
//  1 Reset: arst_wr_n low mid-BURST -> all outputs 0, grant_id_o=0 same cycle; recovers in IDLE.
//  2 RR fairness: all 4 valid, last on every beat, ocup=0 -> grants 0,1,2,3,0, one beat each, 1 idle cycle between.
//  3 Burst cap: req1 valid 10 beats, last on beat 10, MAX_BURST=4 -> 3 grants of 4,4,2 beats.
//  4 Admission: ocup=5 (SLOTS=8, free=3) with req0 valid -> no grant; ocup drops to 4 -> grant next cycle.
//  5 Full stall: fifo_wr_full_i=1 for 20 cycles mid-burst -> no wr_en, ready 0, no timeout; resumes when full=0.
//  6 Timeout: granted req2 drops valid after beat 1 -> release after 16 cycles, rr_ptr=3, req3 next.

Source files
------------

// File: rtl/cdc_fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the write-side FIFO arbiter.
// Holds the FSM state encoding and the round-robin search used by the
// combinational arbiter.
package cdc_fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Widest requester vector the round-robin search handles.
    localparam int RR_MAX   = 32;
    localparam int RR_IDX_W = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid[n-1:0] at or after ptr, wrapping modulo n.
    // Offsets are scanned from the far end so the nearest one is kept last.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                         input int                ptr,
                                         input int                n);
        rr_pick_t            res;
        int                  cand;
        logic [RR_IDX_W-1:0] cidx;
        res = '0;
        for (int off = RR_MAX - 1; off >= 0; off--) begin
            if (off < n) begin
                cand = ptr + off;
                if (cand >= n) begin
                    cand = cand - n;
                end
                cidx = cand[RR_IDX_W-1:0];
                if (valid[cidx]) begin
                    res.found = 1'b1;
                    res.idx   = cidx;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cdc_fifo_wr_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or after the
// rotating pointer, reported both as an index and as a one-hot vector.
module cdc_fifo_wr_arbiter_rr
    import cdc_fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   win_idx,
    output logic [NUM_REQ-1:0] win_onehot
);

    rr_pick_t pick;

    // Search from the pointer and expand the winner into both encodings.
    always_comb begin
        pick       = rr_pick(RR_MAX'(valid), int'(rr_ptr), NUM_REQ);
        found      = pick.found;
        win_idx    = IDX_W'(pick.idx);
        win_onehot = '0;
        if (pick.found) begin
            win_onehot = NUM_REQ'(1) << win_idx;
        end
    end

endmodule

// File: rtl/cdc_fifo_wr_arbiter.sv
// Write-port arbiter for a CDC FIFO with occupancy feedback.
// Round-robin, burst-locked: a winner owns the FIFO write port until its
// last beat, MAX_BURST beats, or IDLE_TMO consecutive cycles without valid.
// A burst is only admitted when the FIFO reports room for MAX_BURST beats.
module cdc_fifo_wr_arbiter
    import cdc_fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int SLOTS     = 8,
    parameter int MAX_BURST = 4,
    parameter int IDLE_TMO  = 16
) (
    input  logic                             clk_wr,
    input  logic                             arst_wr_n,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]    req_data_i,
    input  logic [NUM_REQ-1:0]               req_last_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic                             fifo_wr_en_o,
    output logic [WIDTH-1:0]                 fifo_wr_data_o,
    input  logic                             fifo_wr_full_i,
    input  logic [$clog2(SLOTS):0]           fifo_ocup_i,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id_o,
    output logic                             busy_o
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int OCUP_W = $clog2(SLOTS) + 1;
    localparam int BEAT_W = $clog2(MAX_BURST) + 1;
    localparam int TMO_W  = $clog2(IDLE_TMO) + 1;

    arb_state_t           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_id;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [TMO_W-1:0]     tmo_cnt;

    logic [OCUP_W-1:0]    free_slots;
    logic                 admit;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]   pick_oh;

    logic                 in_burst;
    logic                 g_valid;
    logic                 g_last;
    logic                 beat;
    logic                 burst_end;
    logic                 tmo_hit;
    logic [IDX_W-1:0]     next_ptr;

    cdc_fifo_wr_arbiter_rr #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .valid      (req_valid_i),
        .rr_ptr     (rr_ptr),
        .found      (pick_found),
        .win_idx    (pick_idx),
        .win_onehot (pick_oh)
    );

    // Admission check and per-cycle burst decisions for the granted requester.
    always_comb begin
        free_slots = OCUP_W'(SLOTS) - fifo_ocup_i;
        admit      = (free_slots >= OCUP_W'(MAX_BURST));
        in_burst   = (state == BURST);
        g_valid    = req_valid_i[grant_id];
        g_last     = req_last_i[grant_id];
        beat       = in_burst && g_valid && !fifo_wr_full_i;
        burst_end  = beat && (g_last || (beat_cnt == BEAT_W'(MAX_BURST - 1)));
        tmo_hit    = in_burst && !g_valid && (tmo_cnt == TMO_W'(IDLE_TMO - 1));
        next_ptr   = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

    // Steer the granted requester onto the FIFO write port; quiet outside BURST.
    always_comb begin
        fifo_wr_en_o   = beat;
        req_ready_o    = beat ? grant_oh : '0;
        fifo_wr_data_o = in_burst ? req_data_i[grant_id] : '0;
        grant_id_o     = grant_id;
        busy_o         = in_burst;
    end

    // Arbitration FSM: grant in IDLE, count beats and stall cycles in BURST.
    always_ff @(posedge clk_wr or negedge arst_wr_n) begin
        if (!arst_wr_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            grant_oh <= '0;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found && admit) begin
                        grant_id <= pick_idx;
                        grant_oh <= pick_oh;
                        beat_cnt <= '0;
                        tmo_cnt  <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (burst_end || tmo_hit) begin
                        state    <= IDLE;
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                        tmo_cnt  <= '0;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        tmo_cnt  <= '0;
                    end else if (!g_valid) begin
                        tmo_cnt  <= tmo_cnt + 1'b1;
                    end
                    // Valid high but FIFO full: hold both counters.
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_ready_onehot0 : assert property (@(posedge clk_wr) disable iff (!arst_wr_n)
        $onehot0(req_ready_o));

    a_no_write_when_full : assert property (@(posedge clk_wr) disable iff (!arst_wr_n)
        !(fifo_wr_en_o && fifo_wr_full_i));

    a_burst_fits_fifo : assert property (@(posedge clk_wr) disable iff (!arst_wr_n)
        (MAX_BURST >= 1) && (MAX_BURST <= SLOTS));

    a_slots_pow2 : assert property (@(posedge clk_wr) disable iff (!arst_wr_n)
        (SLOTS > 0) && ((SLOTS & (SLOTS - 1)) == 0));

endmodule

// File: tb/tb_cdc_fifo_wr_arbiter.sv
// Bench for cdc_fifo_wr_arbiter: a vector table for round-robin behaviour,
// hand-written sequences for reset, burst cap, admission, full stall and
// timeout, and a write scoreboard fed with expected FIFO data.
module tb_cdc_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 8;
    localparam int SLOTS     = 8;
    localparam int MAX_BURST = 4;
    localparam int IDLE_TMO  = 16;

    logic                          clk_wr = 1'b0;
    logic                          arst_wr_n;
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic                          fifo_wr_en_o;
    logic [WIDTH-1:0]              fifo_wr_data_o;
    logic                          fifo_wr_full_i;
    logic [3:0]                    fifo_ocup_i;
    logic [1:0]                    grant_id_o;
    logic                          busy_o;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic [3:0] ocup;
        logic       full;
        logic       wr_en;
        logic [3:0] ready;
        logic [1:0] grant;
        logic       busy;
        logic [7:0] data;
    } vec_t;

    vec_t tbl[13];

    cdc_fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .SLOTS     (SLOTS),
        .MAX_BURST (MAX_BURST),
        .IDLE_TMO  (IDLE_TMO)
    ) dut (
        .clk_wr         (clk_wr),
        .arst_wr_n      (arst_wr_n),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_last_i     (req_last_i),
        .req_ready_o    (req_ready_o),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .fifo_wr_full_i (fifo_wr_full_i),
        .fifo_ocup_i    (fifo_ocup_i),
        .grant_id_o     (grant_id_o),
        .busy_o         (busy_o)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid_i    = '0;
        req_last_i     = '0;
        fifo_wr_full_i = 1'b0;
        fifo_ocup_i    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data_i[i] = 8'(8'hA0 + i);
        end
    endtask

    task automatic do_reset();
        arst_wr_n = 1'b0;
        clear_inputs();
        exp_q.delete();
        @(negedge clk_wr);
        arst_wr_n = 1'b1;
        step();
    endtask

    // Scoreboard: every FIFO write must match the next expected beat.
    always @(negedge clk_wr) begin
        if (arst_wr_n === 1'b1) begin
            chk("ready_onehot0", 32'($onehot0(req_ready_o)), 1);
            if (fifo_wr_en_o === 1'b1) begin
                chk("wr_while_full", 32'(fifo_wr_full_i), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got data 0x%0h, required no write", fifo_wr_data_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("wr_data", 32'(fifo_wr_data_o), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int sent;
        int seg;
        int stall;
        int segs[$];

        // valid last ocup full | wr_en ready grant busy data
        tbl[0]  = '{4'hF, 4'hF, 4'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00};
        tbl[1]  = '{4'hF, 4'hF, 4'd0, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 8'hA0};
        tbl[2]  = '{4'hF, 4'hF, 4'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00};
        tbl[3]  = '{4'hF, 4'hF, 4'd0, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 8'hA1};
        tbl[4]  = '{4'hF, 4'hF, 4'd0, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 8'h00};
        tbl[5]  = '{4'hF, 4'hF, 4'd0, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA2};
        tbl[6]  = '{4'hF, 4'hF, 4'd0, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 8'h00};
        tbl[7]  = '{4'hF, 4'hF, 4'd0, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 8'hA3};
        tbl[8]  = '{4'hF, 4'hF, 4'd0, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 8'h00};
        tbl[9]  = '{4'hF, 4'hF, 4'd0, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 8'hA0};
        tbl[10] = '{4'hF, 4'hF, 4'd0, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00};
        tbl[11] = '{4'hF, 4'hF, 4'd0, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1, 8'hA1};
        tbl[12] = '{4'hF, 4'hF, 4'd0, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 8'hA1};

        // Reset with every requester asserting: nothing may move.
        arst_wr_n = 1'b0;
        clear_inputs();
        req_valid_i = 4'hF;
        @(negedge clk_wr);
        chk("rst_busy",  32'(busy_o), 0);
        chk("rst_wr_en", 32'(fifo_wr_en_o), 0);
        chk("rst_ready", 32'(req_ready_o), 0);
        chk("rst_grant", 32'(grant_id_o), 0);
        chk("rst_data",  32'(fifo_wr_data_o), 0);
        req_valid_i = '0;
        arst_wr_n   = 1'b1;
        step();

        // Round-robin fairness table plus full-stall rows.
        for (int i = 0; i < 13; i++) begin
            req_valid_i    = tbl[i].valid;
            req_last_i     = tbl[i].last;
            fifo_ocup_i    = tbl[i].ocup;
            fifo_wr_full_i = tbl[i].full;
            if (tbl[i].wr_en) exp_q.push_back(tbl[i].data);
            @(negedge clk_wr);
            chk($sformatf("row%0d_wr_en", i), 32'(fifo_wr_en_o),   32'(tbl[i].wr_en));
            chk($sformatf("row%0d_ready", i), 32'(req_ready_o),    32'(tbl[i].ready));
            chk($sformatf("row%0d_grant", i), 32'(grant_id_o),     32'(tbl[i].grant));
            chk($sformatf("row%0d_busy", i),  32'(busy_o),         32'(tbl[i].busy));
            chk($sformatf("row%0d_data", i),  32'(fifo_wr_data_o), 32'(tbl[i].data));
            step();
        end
        req_valid_i = '0;

        // Reset mid-burst: outputs drop at once, then arbitration restarts.
        do_reset();
        req_valid_i = 4'b0010;
        @(negedge clk_wr);
        step();
        exp_q.push_back(8'hA1);
        @(negedge clk_wr);
        chk("mid_beat", 32'(fifo_wr_en_o), 1);
        step();
        #2;
        arst_wr_n = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(busy_o), 0);
        chk("mid_rst_wr_en", 32'(fifo_wr_en_o), 0);
        chk("mid_rst_ready", 32'(req_ready_o), 0);
        chk("mid_rst_grant", 32'(grant_id_o), 0);
        chk("mid_rst_data",  32'(fifo_wr_data_o), 0);
        @(negedge clk_wr);
        arst_wr_n = 1'b1;
        #1;
        chk("mid_rst_idle", 32'(busy_o), 0);
        step();
        exp_q.push_back(8'hA1);
        @(negedge clk_wr);
        chk("mid_rst_regrant", 32'(grant_id_o), 1);
        chk("mid_rst_rebeat",  32'(req_ready_o), 32'(4'b0010));
        step();

        // Burst cap: a 10-beat packet is split into 4, 4, 2.
        do_reset();
        for (int b = 0; b < 10; b++) exp_q.push_back(8'(8'h10 + b));
        sent = 0;
        seg  = 0;
        for (int c = 0; c < 30; c++) begin
            req_valid_i[1] = (sent < 10);
            req_data_i[1]  = 8'(8'h10 + sent);
            req_last_i[1]  = (sent == 9);
            @(negedge clk_wr);
            if (req_ready_o[1]) begin
                sent++;
                seg++;
            end else if (!busy_o && seg > 0) begin
                segs.push_back(seg);
                seg = 0;
            end
            step();
        end
        chk("cap_sent", 32'(sent), 10);
        chk("cap_nseg", 32'(segs.size()), 3);
        chk("cap_seg0", 32'((segs.size() > 0) ? segs[0] : 0), 4);
        chk("cap_seg1", 32'((segs.size() > 1) ? segs[1] : 0), 4);
        chk("cap_seg2", 32'((segs.size() > 2) ? segs[2] : 0), 2);

        // Admission: free=3 blocks the grant, free=4 allows it.
        do_reset();
        fifo_ocup_i   = 4'd5;
        req_valid_i   = 4'b0001;
        req_last_i    = 4'b0001;
        req_data_i[0] = 8'h55;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_wr);
            chk("adm_block_busy",  32'(busy_o), 0);
            chk("adm_block_ready", 32'(req_ready_o), 0);
            step();
        end
        fifo_ocup_i = 4'd4;
        @(negedge clk_wr);
        chk("adm_arb_cycle", 32'(busy_o), 0);
        step();
        exp_q.push_back(8'h55);
        @(negedge clk_wr);
        chk("adm_grant_busy", 32'(busy_o), 1);
        chk("adm_grant_id",   32'(grant_id_o), 0);
        chk("adm_grant_wr",   32'(fifo_wr_en_o), 1);
        step();
        req_valid_i = '0;

        // Full stall longer than the timeout: no write, no release.
        do_reset();
        req_valid_i   = 4'b0001;
        req_data_i[0] = 8'h30;
        @(negedge clk_wr);
        step();
        exp_q.push_back(8'h30);
        @(negedge clk_wr);
        chk("stall_first_beat", 32'(fifo_wr_en_o), 1);
        step();
        fifo_wr_full_i = 1'b1;
        req_data_i[0]  = 8'h31;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_wr);
            chk("stall_wr_en", 32'(fifo_wr_en_o), 0);
            chk("stall_ready", 32'(req_ready_o), 0);
            chk("stall_busy",  32'(busy_o), 1);
            step();
        end
        fifo_wr_full_i = 1'b0;
        req_last_i     = 4'b0001;
        exp_q.push_back(8'h31);
        @(negedge clk_wr);
        chk("stall_resume_wr",    32'(fifo_wr_en_o), 1);
        chk("stall_resume_ready", 32'(req_ready_o), 32'(4'b0001));
        step();
        req_valid_i = '0;
        @(negedge clk_wr);
        chk("stall_end_idle", 32'(busy_o), 0);
        step();

        // Timeout: req2 goes quiet after one beat, req3 wins next.
        do_reset();
        req_valid_i   = 4'b0100;
        req_data_i[0] = 8'h60;
        req_data_i[2] = 8'h62;
        req_data_i[3] = 8'h63;
        @(negedge clk_wr);
        step();
        exp_q.push_back(8'h62);
        @(negedge clk_wr);
        chk("tmo_beat_ready", 32'(req_ready_o), 32'(4'b0100));
        step();
        req_valid_i = 4'b1001;
        req_last_i  = 4'b1001;
        stall = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_wr);
            if (!busy_o) break;
            stall++;
            step();
        end
        chk("tmo_stall_cycles", 32'(stall), 16);
        chk("tmo_idle_grant",   32'(grant_id_o), 2);
        step();
        exp_q.push_back(8'h63);
        @(negedge clk_wr);
        chk("tmo_next_busy",  32'(busy_o), 1);
        chk("tmo_next_grant", 32'(grant_id_o), 3);
        chk("tmo_next_ready", 32'(req_ready_o), 32'(4'b1000));
        step();
        req_valid_i = '0;
        repeat (3) step();

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
